// File: rtl/way_select_ctrl.sv
// way_select_ctrl: tag lookup, pseudo-LRU victim selection and flush sweep for a set-associative cache
module way_select_ctrl #(
   parameter int WAYS     = 4,
   parameter int SETS     = 16,
   parameter int TAG_BITS = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_req_valid,
   output logic                     o_req_ready,
   input  logic [$clog2(SETS)-1:0]  i_req_index,
   input  logic [TAG_BITS-1:0]      i_req_tag,
   input  logic                     i_req_alloc,
   input  logic                     i_flush,
   output logic                     o_rsp_valid,
   output logic                     o_hit,
   output logic [WAYS-1:0]          o_way_sel,
   output logic [WAYS-1:0]          o_victim,
   output logic                     o_busy
);
   localparam int IDX_BITS = $clog2(SETS);
   localparam int LVL      = $clog2(WAYS);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] FLUSH = 1'b1;

   logic [0:0]          state;
   logic [IDX_BITS-1:0] cnt;
   logic [TAG_BITS-1:0] tags  [SETS][WAYS];
   logic [WAYS-1:0]     valid [SETS];
   logic [WAYS-1:1]     plru  [SETS];

   logic                accept, hit_any, inv_any, install;
   logic [WAYS-1:0]     hit_vec, victim_vec;
   logic [LVL-1:0]      hit_idx, inv_idx, walk_idx, vic_idx, tgt_idx, node, pre;
   logic [WAYS-1:1]     cur_plru, nxt_plru;

   assign o_req_ready = (state == IDLE);
   assign o_busy      = (state == FLUSH);
   assign accept      = i_req_valid & o_req_ready;

   // tag compare, victim choice and PLRU next-state for the indexed set
   always_comb begin
      hit_vec  = '0;
      hit_idx  = '0;
      inv_any  = 1'b0;
      inv_idx  = '0;
      cur_plru = plru[i_req_index];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid[i_req_index][w] && tags[i_req_index][w] == i_req_tag) begin
            hit_vec[w] = 1'b1;
            hit_idx    = LVL'(w);
         end
         if (!valid[i_req_index][w]) begin
            inv_any = 1'b1;
            inv_idx = LVL'(w);
         end
      end
      hit_any = |hit_vec;
      pre     = '0;
      for (int l = 0; l < LVL; l++) begin
         node = LVL'(1 << l) | pre;
         pre  = LVL'({pre, cur_plru[node]});
      end
      walk_idx   = pre;
      vic_idx    = inv_any ? inv_idx : walk_idx;
      victim_vec = WAYS'(1) << vic_idx;
      install    = accept & ~hit_any & i_req_alloc;
      tgt_idx    = hit_any ? hit_idx : vic_idx;
      nxt_plru   = cur_plru;
      for (int l = 0; l < LVL; l++) begin
         node           = LVL'(1 << l) | LVL'(tgt_idx >> (LVL - l));
         nxt_plru[node] = ~tgt_idx[LVL-1-l];
      end
   end

   // FSM, registered response, valid/PLRU updates and flush sweep
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= IDLE;
         cnt         <= '0;
         o_rsp_valid <= 1'b0;
         o_hit       <= 1'b0;
         o_way_sel   <= '0;
         o_victim    <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid[s] <= '0;
            plru[s]  <= '0;
         end
      end else begin
         o_rsp_valid <= accept;
         o_hit       <= accept & hit_any;
         o_way_sel   <= accept ? hit_vec : '0;
         o_victim    <= (accept && !hit_any) ? victim_vec : '0;
         if (accept && (hit_any || i_req_alloc))
            plru[i_req_index] <= nxt_plru;
         if (install)
            valid[i_req_index][vic_idx] <= 1'b1;
         if (state == FLUSH) begin
            valid[cnt] <= '0;
            plru[cnt]  <= '0;
            cnt        <= cnt + 1'b1;
            if (cnt == IDX_BITS'(SETS - 1))
               state <= IDLE;
         end else if (i_flush) begin
            state <= FLUSH;
            cnt   <= '0;
         end
      end
   end

   // tag storage needs no reset; valid bits gate every compare
   always_ff @(posedge i_clk) begin
      if (install)
         tags[i_req_index][vic_idx] <= i_req_tag;
   end
endmodule

// File: tb/tb_way_select_ctrl.sv
// tb_way_select_ctrl: randomized and directed checks against a behavioural cache-directory model
module tb_way_select_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [3:0] req_index = '0;
   logic [7:0] req_tag = '0;
   logic       req_alloc = 1'b0;
   logic       flush = 1'b0;
   logic       rsp_valid, hit, busy;
   logic [3:0] way_sel, victim;

   int checks = 0;
   int passes = 0;

   int mtag  [16][4];
   bit mval  [16][4];
   bit mplru [16][4];

   way_select_ctrl #(.WAYS(4), .SETS(16), .TAG_BITS(8)) dut (
      .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_index(req_index), .i_req_tag(req_tag), .i_req_alloc(req_alloc),
      .i_flush(flush), .o_rsp_valid(rsp_valid), .o_hit(hit), .o_way_sel(way_sel),
      .o_victim(victim), .o_busy(busy)
   );

   always #5 clk = ~clk;

   task automatic mdl_clear();
      for (int s = 0; s < 16; s++)
         for (int w = 0; w < 4; w++) begin
            mval[s][w]  = 1'b0;
            mplru[s][w] = 1'b0;
         end
   endtask

   task automatic mdl_touch(input int s, input int w);
      int n;
      n = w + 4;
      while (n > 1) begin
         mplru[s][n / 2] = (n % 2 == 0);
         n = n / 2;
      end
   endtask

   task automatic mdl_access(input int s, input int tg, input bit al, output logic [9:0] e);
      int h, v, n;
      h = -1;
      v = -1;
      for (int w = 0; w < 4; w++)
         if (mval[s][w] && mtag[s][w] == tg) h = w;
      if (h >= 0) begin
         mdl_touch(s, h);
         e = {2'b11, 4'(1 << h), 4'b0000};
      end else begin
         for (int w = 0; w < 4; w++)
            if (!mval[s][w] && v < 0) v = w;
         if (v < 0) begin
            n = 1;
            while (n < 4) n = 2 * n + int'(mplru[s][n]);
            v = n - 4;
         end
         e = {2'b10, 4'b0000, 4'(1 << v)};
         if (al) begin
            mtag[s][v] = tg;
            mval[s][v] = 1'b1;
            mdl_touch(s, v);
         end
      end
   endtask

   task automatic send(input logic [3:0] idx, input logic [7:0] tg, input logic al,
                       output logic [9:0] got, output logic [9:0] exp);
      @(negedge clk);
      req_valid = 1'b1;
      req_index = idx;
      req_tag   = tg;
      req_alloc = al;
      @(posedge clk);
      #1;
      got = {rsp_valid, hit, way_sel, victim};
      req_valid = 1'b0;
      mdl_access(int'(idx), int'(tg), al, exp);
   endtask

   task automatic count_busy(output int n, output bit ready_ok);
      n = 0;
      ready_ok = 1'b1;
      while (busy && n < 40) begin
         if (req_ready) ready_ok = 1'b0;
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({req_ready, busy, rsp_valid, hit, way_sel, victim} !== 12'b1000_0000_0000)
         $display("FAIL reset_outputs got=%b want=%b", {req_ready, busy, rsp_valid, hit, way_sel, victim}, 12'b1000_0000_0000);
      else passes++;
      mdl_clear();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0) $display("FAIL idle_no_rsp got=%b want=0", rsp_valid);
      else passes++;
   endtask

   task automatic test_basic();
      logic [9:0] g, e;
      send(4'd3, 8'h12, 1'b1, g, e);
      checks++;
      if (g !== 10'b10_0000_0001) $display("FAIL basic_miss got=%b want=%b", g, 10'b10_0000_0001);
      else passes++;
      send(4'd3, 8'h12, 1'b1, g, e);
      checks++;
      if (g !== 10'b11_0001_0000) $display("FAIL basic_hit got=%b want=%b", g, 10'b11_0001_0000);
      else passes++;
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0) $display("FAIL rsp_pulse got=%b want=0", rsp_valid);
      else passes++;
   endtask

   task automatic test_fill_plru();
      logic [9:0] g, e;
      for (int i = 0; i < 4; i++) begin
         send(4'd5, 8'(8'hA0 + i), 1'b1, g, e);
         checks++;
         if (g !== {2'b10, 4'b0000, 4'(1 << i)}) $display("FAIL fill_victim%0d got=%b want=%b", i, g, {2'b10, 4'b0000, 4'(1 << i)});
         else passes++;
      end
      send(4'd5, 8'hA0, 1'b0, g, e);
      checks++;
      if (g !== 10'b11_0001_0000) $display("FAIL fill_hit got=%b want=%b", g, 10'b11_0001_0000);
      else passes++;
      send(4'd5, 8'hB0, 1'b1, g, e);
      checks++;
      if (g !== 10'b10_0000_0100) $display("FAIL plru_victim got=%b want=%b", g, 10'b10_0000_0100);
      else passes++;
   endtask

   task automatic test_noalloc();
      logic [9:0] g, e;
      for (int i = 0; i < 2; i++) begin
         send(4'd7, 8'h55, 1'b0, g, e);
         checks++;
         if (g !== 10'b10_0000_0001) $display("FAIL noalloc%0d got=%b want=%b", i, g, 10'b10_0000_0001);
         else passes++;
      end
   endtask

   task automatic test_random();
      logic [9:0] g, e;
      for (int i = 0; i < 300; i++) begin
         send(4'($urandom_range(0, 15)), 8'($urandom_range(0, 9)), 1'($urandom), g, e);
         checks++;
         if (g !== e) $display("FAIL random%0d got=%b want=%b", i, g, e);
         else passes++;
      end
   endtask

   task automatic test_flush();
      logic [9:0] g, e;
      int n;
      bit ok;
      send(4'd0, 8'h11, 1'b1, g, e);
      send(4'd1, 8'h22, 1'b1, g, e);
      send(4'd15, 8'h33, 1'b1, g, e);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      count_busy(n, ok);
      mdl_clear();
      checks++;
      if (n !== 16 || !ok) $display("FAIL flush_len got=%0d ready_ok=%0d want=16 ready_ok=1", n, ok);
      else passes++;
      checks++;
      if (req_ready !== 1'b1) $display("FAIL flush_ready got=%b want=1", req_ready);
      else passes++;
      send(4'd0, 8'h11, 1'b0, g, e);
      checks++;
      if (g !== 10'b10_0000_0001) $display("FAIL flush_miss0 got=%b want=%b", g, 10'b10_0000_0001);
      else passes++;
      send(4'd15, 8'h33, 1'b0, g, e);
      checks++;
      if (g !== 10'b10_0000_0001) $display("FAIL flush_miss15 got=%b want=%b", g, 10'b10_0000_0001);
      else passes++;
      send(4'd3, 8'h12, 1'b0, g, e);
      checks++;
      if (g !== 10'b10_0000_0001) $display("FAIL flush_miss3 got=%b want=%b", g, 10'b10_0000_0001);
      else passes++;
   endtask

   task automatic test_reset_mid_flush();
      logic [9:0] g, e;
      send(4'd10, 8'h44, 1'b1, g, e);
      send(4'd12, 8'h66, 1'b1, g, e);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, req_ready, rsp_valid} !== 3'b010) $display("FAIL rst_abort got=%b want=010", {busy, req_ready, rsp_valid});
      else passes++;
      mdl_clear();
      @(negedge clk);
      rst = 1'b0;
      send(4'd10, 8'h44, 1'b0, g, e);
      checks++;
      if (g !== 10'b10_0000_0001) $display("FAIL rst_miss10 got=%b want=%b", g, 10'b10_0000_0001);
      else passes++;
      send(4'd12, 8'h66, 1'b0, g, e);
      checks++;
      if (g !== 10'b10_0000_0001) $display("FAIL rst_miss12 got=%b want=%b", g, 10'b10_0000_0001);
      else passes++;
   endtask

   task automatic test_back_to_back();
      logic [9:0] g1, g2, e;
      int n;
      bit ok;
      @(negedge clk);
      req_valid = 1'b1;
      req_index = 4'd2;
      req_tag   = 8'h3C;
      req_alloc = 1'b1;
      @(posedge clk);
      #1;
      g1 = {rsp_valid, hit, way_sel, victim};
      mdl_access(2, 8'h3C, 1'b1, e);
      checks++;
      if (g1 !== 10'b10_0000_0001 || e !== 10'b10_0000_0001) $display("FAIL b2b_first got=%b want=%b", g1, 10'b10_0000_0001);
      else passes++;
      @(posedge clk);
      #1;
      g2 = {rsp_valid, hit, way_sel, victim};
      req_valid = 1'b0;
      mdl_access(2, 8'h3C, 1'b1, e);
      checks++;
      if (g2 !== 10'b11_0001_0000) $display("FAIL b2b_second got=%b want=%b", g2, 10'b11_0001_0000);
      else passes++;
      @(negedge clk);
      req_valid = 1'b1;
      req_alloc = 1'b0;
      flush     = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      flush     = 1'b0;
      checks++;
      if ({rsp_valid, hit, way_sel, victim, busy} !== 11'b11_0001_0000_1)
         $display("FAIL req_flush_rsp got=%b want=%b", {rsp_valid, hit, way_sel, victim, busy}, 11'b11_0001_0000_1);
      else passes++;
      count_busy(n, ok);
      mdl_clear();
      checks++;
      if (n !== 16 || !ok) $display("FAIL req_flush_len got=%0d ready_ok=%0d want=16 ready_ok=1", n, ok);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill_plru();
      test_noalloc();
      test_random();
      test_flush();
      test_reset_mid_flush();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
